// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and decode helpers for alu_muldiv.
// Contents: alu_op_e (6-bit op codes), alu_state_e (IDLE/BUSY), OP_W, is_m_op().
package alu_pkg;

    localparam int unsigned OP_W = 6;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 6'h00,
        OP_SLL    = 6'h01,
        OP_SLT    = 6'h02,
        OP_SLTU   = 6'h03,
        OP_XOR    = 6'h04,
        OP_SRL    = 6'h05,
        OP_OR     = 6'h06,
        OP_AND    = 6'h07,
        OP_SUB    = 6'h08,
        OP_SRA    = 6'h0D,
        OP_BEQ    = 6'h10,
        OP_BNE    = 6'h11,
        OP_BLT    = 6'h14,
        OP_BGE    = 6'h15,
        OP_BLTU   = 6'h16,
        OP_BGEU   = 6'h17,
        OP_MUL    = 6'h20,
        OP_MULH   = 6'h21,
        OP_MULHSU = 6'h22,
        OP_MULHU  = 6'h23,
        OP_DIV    = 6'h24,
        OP_DIVU   = 6'h25,
        OP_REM    = 6'h26,
        OP_REMU   = 6'h27
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alu_state_e;

    // M-extension codes occupy 0x20..0x27
    function automatic logic is_m_op(input logic [OP_W-1:0] op);
        return op[OP_W-1:3] == 3'b100;
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: operation request / result bus of the execution unit.
// master drives in_valid, op, in_a, in_b, kill; slave returns in_ready,
// out_valid, out and fault.
interface alu_muldiv_if #(
    parameter int unsigned XLEN = 32
) ();
    import alu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            kill;
    logic            out_valid;
    logic [XLEN-1:0] out;
    logic            fault;

    modport master (
        output in_valid, op, in_a, in_b, kill,
        input  in_ready, out_valid, out, fault
    );

    modport slave (
        input  in_valid, op, in_a, in_b, kill,
        output in_ready, out_valid, out, fault
    );

endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative M-extension datapath. One bit per cycle, XLEN cycles:
// unsigned shift-add multiply or restoring divide on operand magnitudes, with
// a final sign fix-up. Operands are captured on start.
// Ports: clk, reset_n (sync, active-low), start, kill, op[2:0], a, b in;
//        done_c (final iteration this cycle), result_c (valid with done_c) out.
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;

    logic            active;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nxt;
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] b_mag_r;
    logic [2:0]      op_r;
    logic            neg_r;

    logic            a_neg;
    logic            b_neg;
    logic            neg_in;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   rsh;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    // Operand signedness and magnitudes; neg_in says whether the selected result flips sign
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (op[2]) begin
            a_neg = ~op[0] & a[XLEN-1];
            b_neg = ~op[0] & b[XLEN-1];
        end else begin
            a_neg = (op != 3'd3) & a[XLEN-1];
            b_neg = ~op[1] & b[XLEN-1];
        end
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        // remainder follows the dividend; everything else follows sign difference
        neg_in = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // One iteration: acc = {hi, lo}; hi is partial product / remainder
    always_comb begin
        acc_nxt = acc;
        rsh     = '0;
        sum     = '0;
        if (op_r[2]) begin
            rsh = {acc[PW-1:XLEN], acc[XLEN-1]};
            if (rsh >= {1'b0, b_mag_r}) begin
                acc_nxt = {XLEN'(rsh - {1'b0, b_mag_r}), acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, b_mag_r} : '0);
            acc_nxt = {sum, acc[XLEN-1:1]};
        end
    end

    // Result select with sign fix-up, taken from the final iteration's value
    always_comb begin
        prod_fix = neg_r ? -acc_nxt : acc_nxt;
        quo      = acc_nxt[XLEN-1:0];
        rem      = acc_nxt[PW-1:XLEN];
        result_c = '0;
        case (op_r)
            3'd0:             result_c = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result_c = prod_fix[PW-1:XLEN];
            3'd4, 3'd5:       result_c = neg_r ? -quo : quo;
            default:          result_c = neg_r ? -rem : rem;
        endcase
        done_c = active && (cnt == CW'(XLEN - 1));
    end

    // Iteration state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            b_mag_r <= '0;
            op_r    <= '0;
            neg_r   <= 1'b0;
        end else if (kill) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, a_mag};
            b_mag_r <= b_mag;
            op_r    <= op;
            neg_r   <= neg_in;
        end else if (active) begin
            acc    <= acc_nxt;
            active <= ~done_c;
            cnt    <= done_c ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: handshaked integer execution unit. Base ALU/compare/branch and
// fault/divide special cases complete in one cycle; other M ops run on
// muldiv_iter for XLEN cycles.
// Ports: clk, reset_n (sync, active-low), bus (alu_muldiv_if.slave).
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          M_ENABLE = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_muldiv_if.slave  bus
);
    localparam int unsigned     SW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e      state;
    alu_state_e      state_nxt;
    logic            accept_c;
    logic            iter_c;
    logic            start_c;
    logic            done_c;
    logic            imm_fault_c;
    logic [XLEN-1:0] imm_res_c;
    logic [XLEN-1:0] iter_res_c;
    logic [SW-1:0]   shamt_c;

    assign bus.in_ready = (state == IDLE);
    assign accept_c     = bus.in_valid & bus.in_ready & ~bus.kill;

    // Single-cycle results: base ALU, faults and divide special cases
    always_comb begin
        imm_res_c   = '0;
        imm_fault_c = 1'b0;
        iter_c      = 1'b0;
        shamt_c     = bus.in_b[SW-1:0];
        if (is_m_op(bus.op)) begin
            if (!M_ENABLE) begin
                imm_fault_c = 1'b1;
            end else if (bus.op[2] && bus.in_b == '0) begin
                imm_res_c = bus.op[1] ? bus.in_a : '1;
            end else if (bus.op[2] && !bus.op[0] && bus.in_a == MIN_VAL && bus.in_b == '1) begin
                imm_res_c = bus.op[1] ? '0 : MIN_VAL;
            end else begin
                iter_c = 1'b1;
            end
        end else begin
            case (bus.op)
                OP_ADD:  imm_res_c = bus.in_a + bus.in_b;
                OP_SUB:  imm_res_c = bus.in_a - bus.in_b;
                OP_SLL:  imm_res_c = bus.in_a << shamt_c;
                OP_SRL:  imm_res_c = bus.in_a >> shamt_c;
                OP_SRA:  imm_res_c = $signed(bus.in_a) >>> shamt_c;
                OP_XOR:  imm_res_c = bus.in_a ^ bus.in_b;
                OP_OR:   imm_res_c = bus.in_a | bus.in_b;
                OP_AND:  imm_res_c = bus.in_a & bus.in_b;
                OP_SLT,
                OP_BLT:  imm_res_c = XLEN'($signed(bus.in_a) < $signed(bus.in_b));
                OP_SLTU,
                OP_BLTU: imm_res_c = XLEN'(bus.in_a < bus.in_b);
                OP_BGE:  imm_res_c = XLEN'($signed(bus.in_a) >= $signed(bus.in_b));
                OP_BGEU: imm_res_c = XLEN'(bus.in_a >= bus.in_b);
                OP_BEQ:  imm_res_c = XLEN'(bus.in_a == bus.in_b);
                OP_BNE:  imm_res_c = XLEN'(bus.in_a != bus.in_b);
                default: imm_fault_c = 1'b1;
            endcase
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_c),
        .kill     (bus.kill),
        .op       (bus.op[2:0]),
        .a        (bus.in_a),
        .b        (bus.in_b),
        .done_c   (done_c),
        .result_c (iter_res_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; kill wins over completion
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c && iter_c) begin
                    state_nxt = BUSY;
                    start_c   = 1'b1;
                end
            end
            BUSY: begin
                if (bus.kill || done_c) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Output registers; out holds until the next completed result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.fault     <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.fault     <= 1'b0;
            if (accept_c && !iter_c) begin
                bus.out_valid <= 1'b1;
                bus.out       <= imm_res_c;
                bus.fault     <= imm_fault_c;
            end else if (state == BUSY && !bus.kill && done_c) begin
                bus.out_valid <= 1'b1;
                bus.out       <= iter_res_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv.
// dut32: XLEN=32, M_ENABLE=1. dut64: XLEN=64, M_ENABLE=0.
module tb_alu_muldiv;
    import alu_pkg::*;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        flt;
        logic        iter;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;

    alu_muldiv_if #(.XLEN(32)) b32 ();
    alu_muldiv_if #(.XLEN(64)) b64 ();

    alu_muldiv #(.XLEN(32), .M_ENABLE(1'b1)) dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b32)
    );

    alu_muldiv #(.XLEN(64), .M_ENABLE(1'b0)) dut64 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b64)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        b32.in_valid = 1'b1;
        b32.op       = op;
        b32.in_a     = a;
        b32.in_b     = b;
    endtask

    task automatic idle32();
        b32.in_valid = 1'b0;
        b32.op       = 6'h00;
        b32.in_a     = 32'h0;
        b32.in_b     = 32'h0;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        idle32();
        b32.kill     = 1'b0;
        b64.in_valid = 1'b0;
        b64.op       = 6'h00;
        b64.in_a     = 64'h0;
        b64.in_b     = 64'h0;
        b64.kill     = 1'b0;
        step();
        step();
        vectors++;
        if (b32.out_valid !== 1'b0 || b32.out !== 32'h0 || b32.fault !== 1'b0 || b32.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset32: valid=%b out=%h fault=%b ready=%b, want 0/0/0/1",
                     b32.out_valid, b32.out, b32.fault, b32.in_ready);
        end
        vectors++;
        if (b64.out_valid !== 1'b0 || b64.out !== 64'h0 || b64.fault !== 1'b0 || b64.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset64: valid=%b out=%h fault=%b ready=%b, want 0/0/0/1",
                     b64.out_valid, b64.out, b64.fault, b64.in_ready);
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1/0", b32.in_ready, b32.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        vectors++;
        if (b32.out_valid !== 1'b1 || b32.out !== 32'h8000_0000 || b32.fault !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_add: valid=%b out=%h fault=%b, want 1/80000000/0",
                     b32.out_valid, b32.out, b32.fault);
        end
        drive32(OP_SRA, 32'h8000_0000, 32'h0000_0021);
        step();
        vectors++;
        if (b32.out_valid !== 1'b1 || b32.out !== 32'hC000_0000 || b32.fault !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_sra: valid=%b out=%h fault=%b, want 1/c0000000/0",
                     b32.out_valid, b32.out, b32.fault);
        end
        idle32();
        step();
        vectors++;
        if (b32.out_valid !== 1'b0 || b32.out !== 32'hC000_0000) begin
            miscompares++;
            $display("FAIL b2b_hold: valid=%b out=%h, want 0/c0000000", b32.out_valid, b32.out);
        end
    endtask

    task automatic test_alu();
        vec_t v [11];
        v[0]  = '{OP_BLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h1,         1'b0, 1'b0};
        v[1]  = '{OP_BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         1'b0, 1'b0};
        v[2]  = '{OP_BGE,  32'h0000_0005, 32'h0000_0005, 32'h1,         1'b0, 1'b0};
        v[3]  = '{6'h09,   32'h1234_5678, 32'h0000_0001, 32'h0,         1'b1, 1'b0};
        v[4]  = '{OP_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};
        v[5]  = '{OP_SLTU, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0};
        v[6]  = '{OP_SRL,  32'h8000_0000, 32'h0000_003F, 32'h1,         1'b0, 1'b0};
        v[7]  = '{OP_BNE,  32'h0000_0004, 32'h0000_0004, 32'h0,         1'b0, 1'b0};
        v[8]  = '{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0};
        v[9]  = '{OP_BGEU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0};
        v[10] = '{6'h3F,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive32(v[i].op, v[i].a, v[i].b);
            step();
            vectors++;
            if (b32.out_valid !== 1'b1 || b32.out !== v[i].exp || b32.fault !== v[i].flt) begin
                miscompares++;
                $display("FAIL alu[%0d] op=%h: valid=%b out=%h fault=%b, want 1/%h/%b",
                         i, v[i].op, b32.out_valid, b32.out, b32.fault, v[i].exp, v[i].flt);
            end
        end
        idle32();
        step();
    endtask

    task automatic test_mul();
        vec_t v [5];
        logic bad;
        v[0] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1};
        v[1] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1};
        v[2] = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1};
        v[3] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1};
        v[4] = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive32(v[i].op, v[i].a, v[i].b);
            step();
            b32.in_valid = 1'b0;
            b32.in_a     = 32'hDEAD_BEEF;
            b32.in_b     = 32'h0000_0000;
            bad = 1'b0;
            for (int k = 1; k <= 32; k++) begin
                if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b0) bad = 1'b1;
                step();
            end
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL mul_busy[%0d]: ready/valid not 0/0 throughout busy window", i);
            end
            vectors++;
            if (b32.out_valid !== 1'b1 || b32.out !== v[i].exp || b32.fault !== 1'b0 || b32.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL mul[%0d] op=%h: valid=%b out=%h fault=%b ready=%b, want 1/%h/0/1",
                         i, v[i].op, b32.out_valid, b32.out, b32.fault, b32.in_ready, v[i].exp);
            end
        end
        idle32();
        step();
        vectors++;
        if (b32.out_valid !== 1'b0 || b32.out !== 32'h0) begin
            miscompares++;
            $display("FAIL mul_pulse: valid=%b out=%h, want 0/00000000", b32.out_valid, b32.out);
        end
    endtask

    task automatic test_div();
        vec_t v [10];
        logic bad;
        v[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 1'b1};
        v[1] = '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b1};
        v[2] = '{OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 1'b1};
        v[3] = '{OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b1};
        v[4] = '{OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1};
        v[5] = '{OP_DIVU, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
        v[6] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        v[7] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0};
        v[8] = '{OP_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0};
        v[9] = '{OP_DIV,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive32(v[i].op, v[i].a, v[i].b);
            step();
            b32.in_valid = 1'b0;
            b32.in_a     = 32'hDEAD_BEEF;
            b32.in_b     = 32'h0000_0000;
            if (v[i].iter) begin
                bad = 1'b0;
                for (int k = 1; k <= 32; k++) begin
                    if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b0) bad = 1'b1;
                    step();
                end
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL div_busy[%0d]: ready/valid not 0/0 throughout busy window", i);
                end
            end
            vectors++;
            if (b32.out_valid !== 1'b1 || b32.out !== v[i].exp || b32.fault !== 1'b0 || b32.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL div[%0d] op=%h: valid=%b out=%h fault=%b ready=%b, want 1/%h/0/1",
                         i, v[i].op, b32.out_valid, b32.out, b32.fault, b32.in_ready, v[i].exp);
            end
        end
        idle32();
        step();
    endtask

    task automatic test_kill();
        logic bad;
        drive32(OP_ADD, 32'h1, 32'h2);
        step();
        vectors++;
        if (b32.out_valid !== 1'b1 || b32.out !== 32'h3) begin
            miscompares++;
            $display("FAIL kill_setup: valid=%b out=%h, want 1/00000003", b32.out_valid, b32.out);
        end
        drive32(OP_DIVU, 32'd100, 32'd7);
        step();
        b32.in_valid = 1'b0;
        repeat (9) step();
        vectors++;
        if (b32.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_busy: ready=%b, want 0", b32.in_ready);
        end
        b32.kill = 1'b1;
        step();
        b32.kill = 1'b0;
        vectors++;
        if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0 || b32.out !== 32'h3) begin
            miscompares++;
            $display("FAIL kill_abort: ready=%b valid=%b out=%h, want 1/0/00000003",
                     b32.in_ready, b32.out_valid, b32.out);
        end
        bad = 1'b0;
        repeat (34) begin
            if (b32.out_valid !== 1'b0 || b32.out !== 32'h3) bad = 1'b1;
            step();
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL kill_quiet: stray out_valid or out change after kill, want none");
        end
        drive32(OP_ADD, 32'h5, 32'h5);
        b32.kill = 1'b1;
        step();
        b32.kill = 1'b0;
        b32.in_valid = 1'b0;
        vectors++;
        if (b32.out_valid !== 1'b0 || b32.out !== 32'h3) begin
            miscompares++;
            $display("FAIL kill_idle: valid=%b out=%h, want 0/00000003", b32.out_valid, b32.out);
        end
        drive32(OP_DIVU, 32'd1000, 32'd10);
        step();
        b32.in_valid = 1'b0;
        bad = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b0) bad = 1'b1;
            step();
        end
        vectors++;
        if (bad || b32.out_valid !== 1'b1 || b32.out !== 32'd100) begin
            miscompares++;
            $display("FAIL kill_restart: busy_err=%b valid=%b out=%h, want 0/1/00000064",
                     bad, b32.out_valid, b32.out);
        end
        idle32();
        step();
    endtask

    task automatic test_reset_mid();
        logic bad;
        drive32(OP_MUL, 32'h7, 32'hFFFF_FFFD);
        step();
        b32.in_valid = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        step();
        vectors++;
        if (b32.out_valid !== 1'b0 || b32.out !== 32'h0 || b32.fault !== 1'b0 || b32.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b out=%h fault=%b ready=%b, want 0/0/0/1",
                     b32.out_valid, b32.out, b32.fault, b32.in_ready);
        end
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (34) begin
            if (b32.out_valid !== 1'b0 || b32.out !== 32'h0) bad = 1'b1;
            step();
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: stray result after mid-op reset, want none");
        end
        drive32(OP_ADD, 32'h2, 32'h2);
        step();
        idle32();
        vectors++;
        if (b32.out_valid !== 1'b1 || b32.out !== 32'h4) begin
            miscompares++;
            $display("FAIL reset_mid_after: valid=%b out=%h, want 1/00000004", b32.out_valid, b32.out);
        end
        step();
    endtask

    task automatic test_xlen64();
        b64.in_valid = 1'b1;
        b64.op       = OP_MULHU;
        b64.in_a     = 64'd5;
        b64.in_b     = 64'd7;
        step();
        vectors++;
        if (b64.out_valid !== 1'b1 || b64.fault !== 1'b1 || b64.out !== 64'h0) begin
            miscompares++;
            $display("FAIL x64_mulhu: valid=%b fault=%b out=%h, want 1/1/0",
                     b64.out_valid, b64.fault, b64.out);
        end
        b64.op   = OP_ADD;
        b64.in_a = 64'h0000_0001_FFFF_FFFF;
        b64.in_b = 64'h0000_0000_0000_0001;
        step();
        vectors++;
        if (b64.out_valid !== 1'b1 || b64.fault !== 1'b0 || b64.out !== 64'h0000_0002_0000_0000) begin
            miscompares++;
            $display("FAIL x64_add: valid=%b fault=%b out=%h, want 1/0/0000000200000000",
                     b64.out_valid, b64.fault, b64.out);
        end
        b64.op   = OP_SLL;
        b64.in_a = 64'h1;
        b64.in_b = 64'h43;
        step();
        vectors++;
        if (b64.out_valid !== 1'b1 || b64.out !== 64'h8) begin
            miscompares++;
            $display("FAIL x64_sll: valid=%b out=%h, want 1/0000000000000008", b64.out_valid, b64.out);
        end
        b64.op   = OP_SRA;
        b64.in_a = 64'h8000_0000_0000_0000;
        b64.in_b = 64'h44;
        step();
        vectors++;
        if (b64.out_valid !== 1'b1 || b64.out !== 64'hF800_0000_0000_0000) begin
            miscompares++;
            $display("FAIL x64_sra: valid=%b out=%h, want 1/f800000000000000", b64.out_valid, b64.out);
        end
        b64.in_valid = 1'b0;
        step();
        vectors++;
        if (b64.out_valid !== 1'b0 || b64.fault !== 1'b0) begin
            miscompares++;
            $display("FAIL x64_idle: valid=%b fault=%b, want 0/0", b64.out_valid, b64.fault);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_alu();
        test_mul();
        test_div();
        test_kill();
        test_reset_mid();
        test_xlen64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, handshaked execution unit for the RV32I/E core. It performs all base integer ALU, compare and branch-condition operations with a latency of 1 cycle. It also performs the RV M-extension multiply/divide operations using an iterative multi-cycle datapath. It sits between decode and writeback, and the front end stalls on `in_ready`.

## Interface
- `XLEN`, default 32: operand and result width. Must be a power of two, 8 or greater.
- `M_ENABLE`, default 1: when 0, every M-extension op returns a fault.
- `clk` input, 1 bit: clock.
- `reset_n` input, 1 bit: reset, synchronous, active-low.
- `in_valid` input, 1 bit: an operation is presented.
- `in_ready` output, 1 bit: the unit can accept an operation.
- `op` input, 6 bits: operation code (see Operation).
- `in_a` input, XLEN bits: operand A.
- `in_b` input, XLEN bits: operand B.
- `kill` input, 1 bit: aborts any in-flight or presented operation.
- `out_valid` output, 1 bit: single-cycle pulse marking a completed result.
- `out` output, XLEN bits: result. Held until the next `out_valid`.
- `fault` output, 1 bit: invalid op. Qualified by `out_valid`.

## Operation
- Op codes, base set:
  - 0x00 ADD, 0x01 SLL, 0x02 SLT, 0x03 SLTU, 0x04 XOR, 0x05 SRL, 0x06 OR, 0x07 AND, 0x08 SUB, 0x0D SRA.
  - 0x10 BEQ, 0x11 BNE, 0x14 BLT, 0x15 BGE, 0x16 BLTU, 0x17 BGEU.
- Op codes, M set: 0x20 MUL, 0x21 MULH, 0x22 MULHSU, 0x23 MULHU, 0x24 DIV, 0x25 DIVU, 0x26 REM, 0x27 REMU.
- Any other code, or an M code when M_ENABLE=0: `fault`=1 and `out`=0, with 1-cycle latency.
- Compare and branch ops return 1 or 0, zero-extended to XLEN.
- Shift amount is `in_b[$clog2(XLEN)-1:0]`. Upper bits of `in_b` are ignored.
- Arithmetic wraps modulo 2^XLEN.
- MUL returns the low XLEN bits of the 2·XLEN product. MULH, MULHSU and MULHU return the high XLEN bits, treating operands as signed×signed, signed×unsigned and unsigned×unsigned respectively.
- Multiply datapath:
  - Operands are converted to magnitudes.
  - One bit per cycle, unsigned shift-add, XLEN iterations.
  - The 2·XLEN product is negated at the end when the operand signs differ.
- Divide datapath: restoring division, one quotient bit per cycle, XLEN iterations.
- Divide sign rules:
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - DIV and REM truncate toward zero.
- Divide special cases, resolved at acceptance with 1-cycle latency and no iteration:
  - Divide by zero: quotient is all-ones, remainder = `in_a`.
  - Signed overflow (DIV/REM with `in_a`=min and `in_b`=−1): quotient = min, remainder = 0.
- State machine `IDLE` / `BUSY`:
  - `in_ready` = (state==IDLE).
  - Accept = `in_valid` & `in_ready` & ~`kill`.
  - A non-special M op accepted in IDLE moves to BUSY.
  - BUSY moves to IDLE on the final iteration, with `out_valid` asserted on the next cycle.
- `kill` has priority over everything:
  - In BUSY: return to IDLE next cycle. No `out_valid`, and `out` is unchanged.
  - In IDLE: the presented op is not accepted.
- Operands and op are captured at accept. Input changes while BUSY have no effect.

## Timing
- Reset (reset_n low at a clk edge): state=IDLE, `out`=0, `out_valid`=0, `fault`=0, iteration counter=0. `in_ready`=1 from the first cycle after reset.
- Reset mid-operation behaves as above. The partial result is discarded.
- Base, fault and special-case ops: accepted at edge N, `out_valid` high for cycle N+1. A back-to-back accept is allowed at N+1.
- Iterative ops: accepted at edge N, `in_ready` low for cycles N+1 through N+XLEN, `out_valid` in cycle N+XLEN+1.
- `in_ready` is high again in the same cycle `out_valid` is asserted. An accept in that cycle is legal.
- `out_valid` is never asserted for two cycles because of one operation.
- `fault`=0 whenever `out_valid`=0.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_e`, a 6-bit enum of all codes above;
  - `alu_state_e` (IDLE, BUSY);
  - the helper function `is_m_op`.
- Sub-module `muldiv_iter` holds the magnitude conversion, iteration counter, shift-add/restoring datapath and final sign fix-up.
  - Its interface is start/done/kill, with op[2:0] and the operands.
- The top level holds the combinational base ALU, op decode and fault detection, the FSM, and the output registers.

## Test plan
- Reset with XLEN=32. Send ADD 0x7FFFFFFF+1 → 0x80000000 one cycle later. Then SRA 0x80000000 by in_b=0x21 → 0xC0000000 (shift amount 1). Both issued back-to-back.
- BLT −1 vs 1 → 1. BLTU 0xFFFFFFFF vs 1 → 0. BGE equal operands → 1. Op 0x09 → fault=1, out=0.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF. MUL 7×−3 → 0xFFFFFFEB. Each has `out_valid` exactly XLEN+1 cycles after accept and `in_ready`=0 in between.
- DIV −7/2 → −3 and REM −7/2 → −1 after XLEN+1 cycles. DIVU x/0 → 0xFFFFFFFF and REM 0x80000000/−1 → 0, each after 1 cycle.
- Assert `kill` at cycle 10 of a DIVU → no `out_valid`, `in_ready`=1 next cycle, `out` keeps its prior value. Then reset_n low mid-MUL → all outputs 0.
- XLEN=64 with M_ENABLE=0: MULHU → fault after 1 cycle. ADD of 64-bit operands is correct. SLL by in_b=0x43 → shift by 3.
